// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED PIO sequencer: config register map, mode codes, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package led_seq_pkg;

    localparam logic [1:0] REG_CONTROL = 2'd0;
    localparam logic [1:0] REG_HALF    = 2'd1;
    localparam logic [1:0] REG_BURST   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/led_seq_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at 0.
// Zero flag is combinational from the count; no backpressure.
module led_seq_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous Avalon-MM writer for the LED PIO (off/on/blink/burst), configured via a 4-register slave.
// CONTROL write to PIO chipselect: 1 cycle; PIO writes hold stable while pio_waitrequest is high.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 25000000,
    parameter int BURST_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic        pio_waitrequest,
    output logic        led_level
);

    logic               r_enable;
    mode_e              r_mode;
    logic [CNT_W-1:0]   r_half;
    logic [BURST_W-1:0] r_burst_cfg;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_done;
    logic               r_led;
    logic               r_target;
    logic               r_reeval;
    state_e             r_state;

    logic               w_cfg_wr;
    logic               w_ctrl_wr;
    logic               w_en;
    mode_e              w_mode;
    logic               w_tgt;
    logic               w_commit;
    logic               w_periodic;
    logic               w_burst_end;
    logic               w_to_wait;
    logic               w_tmr_zero;
    logic               w_busy;
    logic [CNT_W-1:0]   w_half_m1;

    assign w_cfg_wr  = cfg_chipselect && !cfg_write_n && (cfg_address != REG_STATUS);
    assign w_ctrl_wr = w_cfg_wr && (cfg_address == REG_CONTROL);

    // A CONTROL write is evaluated in the same cycle so the PIO write starts on the next one.
    assign w_en   = w_ctrl_wr ? cfg_writedata[0] : r_enable;
    assign w_mode = w_ctrl_wr ? mode_e'(cfg_writedata[2:1]) : r_mode;
    assign w_tgt  = w_en && (w_mode != MODE_OFF);

    assign w_commit    = (r_state == ST_ISSUE) && !pio_waitrequest;
    assign w_periodic  = r_enable && ((r_mode == MODE_BLINK) || (r_mode == MODE_BURST));
    assign w_burst_end = (r_mode == MODE_BURST) && !r_target && (r_burst_cnt == BURST_W'(1));
    assign w_to_wait   = w_commit && !r_reeval && !w_cfg_wr && w_periodic && !w_burst_end;
    assign w_half_m1   = (r_half == '0) ? '0 : r_half - CNT_W'(1);
    assign w_busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    led_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_to_wait),
        .i_load_val (w_half_m1),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable    <= 1'b0;
            r_mode      <= MODE_OFF;
            r_half      <= CNT_W'(DEFAULT_HALF);
            r_burst_cfg <= BURST_W'(1);
        end else if (w_cfg_wr) begin
            case (cfg_address)
                REG_CONTROL: begin
                    r_enable <= cfg_writedata[0];
                    r_mode   <= mode_e'(cfg_writedata[2:1]);
                end
                REG_HALF:  r_half      <= cfg_writedata[CNT_W-1:0];
                REG_BURST: r_burst_cfg <= cfg_writedata[BURST_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_done         <= 1'b0;
            r_led          <= 1'b0;
            r_target       <= 1'b0;
            r_reeval       <= 1'b0;
            r_burst_cnt    <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_done <= 1'b0;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if ((r_state == ST_IDLE) || w_ctrl_wr) begin
                        if (w_en && (w_mode == MODE_BURST) && (r_burst_cfg == '0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_en && ((w_mode == MODE_BLINK) || (w_mode == MODE_BURST))) begin
                            r_target       <= 1'b1;
                            r_burst_cnt    <= r_burst_cfg;
                            pio_chipselect <= 1'b1;
                            pio_write_n    <= 1'b0;
                            pio_writedata  <= 32'd1;
                            r_state        <= ST_ISSUE;
                        end else if (w_tgt != r_led) begin
                            r_target       <= w_tgt;
                            pio_chipselect <= 1'b1;
                            pio_write_n    <= 1'b0;
                            pio_writedata  <= {31'd0, w_tgt};
                            r_state        <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Config changes mid-write never alter the in-flight data; they force a re-evaluation.
                    if (w_cfg_wr) begin
                        r_reeval <= 1'b1;
                    end
                    if (w_commit) begin
                        pio_chipselect <= 1'b0;
                        pio_write_n    <= 1'b1;
                        r_led          <= r_target;
                        r_reeval       <= 1'b0;
                        if ((r_mode == MODE_BURST) && !r_target) begin
                            r_burst_cnt <= r_burst_cnt - BURST_W'(1);
                        end
                        if (w_to_wait) begin
                            r_state <= ST_WAIT;
                        end else if (w_burst_end && w_periodic && !r_reeval && !w_cfg_wr) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_cfg_wr) begin
                        r_state <= ST_IDLE;
                    end else if (w_tmr_zero) begin
                        r_target       <= !r_target;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= {31'd0, !r_target};
                        r_state        <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            REG_CONTROL: cfg_readdata = {29'd0, r_mode, r_enable};
            REG_HALF:    cfg_readdata[CNT_W-1:0]   = r_half;
            REG_BURST:   cfg_readdata[BURST_W-1:0] = r_burst_cfg;
            REG_STATUS:  cfg_readdata = {29'd0, r_done, r_led, w_busy};
            default:     cfg_readdata = '0;
        endcase
    end

    assign pio_address = 2'b00;
    assign led_level   = r_led;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: directed corner cases plus randomized mode/period/burst trials.
// Expected PIO write schedules come from arithmetic on the pattern rules, not from the FSM.
module tb_led_pio_sequencer;
    import led_seq_pkg::*;

    localparam int DEFAULT_HALF = 25000000;
    localparam int WIN          = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_address = 2'd0;
    logic        cfg_chipselect = 1'b0;
    logic        cfg_write_n = 1'b1;
    logic [31:0] cfg_writedata = 32'd0;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        pio_waitrequest = 1'b0;
    logic        led_level;

    led_pio_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_address     (cfg_address),
        .cfg_chipselect  (cfg_chipselect),
        .cfg_write_n     (cfg_write_n),
        .cfg_writedata   (cfg_writedata),
        .cfg_readdata    (cfg_readdata),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_waitrequest (pio_waitrequest),
        .led_level       (led_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Completed PIO writes: cycle index and data.
    int          q_cyc[$];
    logic [31:0] q_dat[$];
    always @(negedge clk) begin
        if (pio_chipselect && !pio_write_n && !pio_waitrequest) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(pio_writedata);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q_cyc.delete();
        q_dat.delete();
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d, output int t);
        @(negedge clk);
        cfg_address    = a;
        cfg_writedata  = d;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        t = cyc;
        @(negedge clk);
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
        cfg_address = a;
        #1;
        d = cfg_readdata;
    endtask

    task automatic run_trial(input bit en, input int mode, input int half, input int burst);
        int          t;
        int          h;
        int          e_cyc[$];
        logic [31:0] e_dat[$];
        logic [31:0] st;
        logic [31:0] exp_st;
        do_reset();
        cfg_wr(REG_HALF, 32'(half), t);
        cfg_wr(REG_BURST, 32'(burst), t);
        cfg_wr(REG_CONTROL, {29'd0, mode[1:0], en}, t);
        h = (half == 0) ? 1 : half;
        if (en && mode == 1) begin
            e_cyc.push_back(t + 1);
            e_dat.push_back(32'd1);
        end else if (en && mode == 2) begin
            for (int k = 0; t + 1 + k * (h + 1) <= t + 1 + WIN; k++) begin
                e_cyc.push_back(t + 1 + k * (h + 1));
                e_dat.push_back((k % 2 == 0) ? 32'd1 : 32'd0);
            end
        end else if (en && mode == 3) begin
            for (int k = 0; k < 2 * burst; k++) begin
                e_cyc.push_back(t + 1 + k * (h + 1));
                e_dat.push_back((k % 2 == 0) ? 32'd1 : 32'd0);
            end
        end
        repeat (WIN) @(negedge clk);
        #1;
        check($sformatf("nwr(en%0d m%0d h%0d b%0d)", en, mode, half, burst), 32'(q_cyc.size()), 32'(e_cyc.size()));
        for (int i = 0; i < e_cyc.size() && i < q_cyc.size(); i++) begin
            check($sformatf("wr%0d_cyc(m%0d h%0d)", i, mode, half), 32'(q_cyc[i] - t), 32'(e_cyc[i] - t));
            check($sformatf("wr%0d_dat(m%0d h%0d)", i, mode, half), q_dat[i], e_dat[i]);
        end
        cfg_rd(REG_STATUS, st);
        if (en && mode == 2) begin
            check("blink_busy", st & 32'd1, 32'd1);
        end else begin
            exp_st = (en && mode == 1) ? 32'd2 : (en && mode == 3) ? 32'd4 : 32'd0;
            check($sformatf("status(en%0d m%0d b%0d)", en, mode, burst), st, exp_st);
        end
    endtask

    initial begin
        int          t;
        logic [31:0] rd;

        // Reset state and single "on" write.
        do_reset();
        #1;
        check("rst_cs", 32'(pio_chipselect), 32'd0);
        check("rst_wn", 32'(pio_write_n), 32'd1);
        check("rst_wd", pio_writedata, 32'd0);
        check("rst_led", 32'(led_level), 32'd0);
        check("rst_addr", 32'(pio_address), 32'd0);
        cfg_rd(REG_CONTROL, rd); check("rst_ctrl", rd, 32'd0);
        cfg_rd(REG_HALF, rd);    check("rst_half", rd, 32'(DEFAULT_HALF));
        cfg_rd(REG_BURST, rd);   check("rst_burst", rd, 32'd1);
        cfg_rd(REG_STATUS, rd);  check("rst_status", rd, 32'd0);
        cfg_wr(REG_CONTROL, 32'h3, t);
        check("on_cs", 32'(pio_chipselect), 32'd1);
        check("on_wn", 32'(pio_write_n), 32'd0);
        check("on_wd", pio_writedata, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("on_led", 32'(led_level), 32'd1);
        check("on_nwr", 32'(q_cyc.size()), 32'd1);
        cfg_rd(REG_STATUS, rd); check("on_status", rd, 32'd2);

        // Stalled write with CONTROL=0 arriving mid-ISSUE.
        do_reset();
        cfg_wr(REG_HALF, 32'd4, t);
        @(negedge clk);
        cfg_address = REG_CONTROL; cfg_writedata = 32'h5;
        cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
        pio_waitrequest = 1'b1;
        t = cyc;
        @(negedge clk);
        cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
        check("stall1_cs", 32'(pio_chipselect), 32'd1);
        check("stall1_wd", pio_writedata, 32'd1);
        @(negedge clk);
        cfg_address = REG_CONTROL; cfg_writedata = 32'h0;
        cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
        check("stall2_wd", pio_writedata, 32'd1);
        @(negedge clk);
        cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
        check("stall3_wd", pio_writedata, 32'd1);
        check("stall3_wn", 32'(pio_write_n), 32'd0);
        @(posedge clk);
        #1 pio_waitrequest = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("stall_nwr", 32'(q_cyc.size()), 32'd2);
        if (q_cyc.size() == 2) begin
            check("stall_w0_cyc", 32'(q_cyc[0] - t), 32'd4);
            check("stall_w0_dat", q_dat[0], 32'd1);
            check("stall_w1_cyc", 32'(q_cyc[1] - t), 32'd6);
            check("stall_w1_dat", q_dat[1], 32'd0);
        end
        cfg_rd(REG_STATUS, rd); check("stall_status", rd, 32'd0);

        // Burst of zero pulses.
        do_reset();
        cfg_wr(REG_BURST, 32'd0, t);
        cfg_wr(REG_CONTROL, 32'h7, t);
        @(negedge clk);
        cfg_rd(REG_STATUS, rd); check("b0_status", rd, 32'd4);
        repeat (8) @(negedge clk);
        #1;
        check("b0_nwr", 32'(q_cyc.size()), 32'd0);

        // Reset while blinking in WAIT.
        do_reset();
        cfg_wr(REG_HALF, 32'd4, t);
        cfg_wr(REG_CONTROL, 32'h5, t);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rw_cs", 32'(pio_chipselect), 32'd0);
        check("rw_wn", 32'(pio_write_n), 32'd1);
        check("rw_wd", pio_writedata, 32'd0);
        check("rw_led", 32'(led_level), 32'd0);
        cfg_rd(REG_HALF, rd);   check("rw_half", rd, 32'(DEFAULT_HALF));
        cfg_rd(REG_STATUS, rd); check("rw_status", rd, 32'd0);
        reset = 1'b0;

        // Directed blink and burst patterns, then randomized trials.
        run_trial(1'b1, 2, 4, 1);
        run_trial(1'b1, 3, 2, 3);
        run_trial(1'b1, 2, 0, 1);
        for (int n = 0; n < 24; n++) begin
            run_trial($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
